alu_op_responder: RTL and testbench

//   Responder (execution) side of the op_valid / operation_done ALU protocol.

---
 rtl/alu_op_responder.sv | 135 +++++++++++++
 tb/tb_alu_op_responder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/alu_op_responder.sv
// alu_op_responder - execution side of the op_valid / operation_done ALU protocol.
// Single-cycle logic/add/shift ops, iterative shift-add multiply, one-cycle done pulse.
module alu_op_responder #(
  parameter int WIDTH    = 32,
  parameter int OP_WIDTH = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [WIDTH-1:0]    operand_a,
  input  logic [WIDTH-1:0]    operand_b,
  input  logic [OP_WIDTH-1:0] operator,
  input  logic                op_valid,
  output logic                operation_done,
  output logic [WIDTH-1:0]    result,
  output logic                busy,
  output logic                op_error
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_SUB = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_AND = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_OR  = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] OP_XOR = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OP_MUL = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] OP_SHL = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] OP_SHR = OP_WIDTH'(7);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      a_q, a_d;
  logic [WIDTH-1:0]      b_q, b_d;
  logic [WIDTH-1:0]      acc_q, acc_d;
  logic [WIDTH-1:0]      result_q, result_d;
  logic [OP_WIDTH-1:0]   op_q, op_d;
  logic [SHW-1:0]        cnt_q, cnt_d;
  logic                  op_error_q, op_error_d;

  logic [WIDTH-1:0]      exec_res;
  logic                  exec_illegal;

  // Single-cycle datapath; MUL never reaches EXEC so its slot is unused here.
  always_comb begin
    exec_res     = '0;
    exec_illegal = 1'b0;
    case (op_q)
      OP_ADD:  exec_res = a_q + b_q;
      OP_SUB:  exec_res = a_q - b_q;
      OP_AND:  exec_res = a_q & b_q;
      OP_OR:   exec_res = a_q | b_q;
      OP_XOR:  exec_res = a_q ^ b_q;
      OP_MUL:  exec_res = '0;
      OP_SHL:  exec_res = a_q << b_q[SHW-1:0];
      OP_SHR:  exec_res = a_q >> b_q[SHW-1:0];
      default: exec_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    result_d   = result_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    op_error_d = op_error_q;
    case (state_q)
      IDLE: begin
        if (op_valid) begin
          a_d        = operand_a;
          b_d        = operand_b;
          op_d       = operator;
          acc_d      = '0;
          cnt_d      = '0;
          op_error_d = 1'b0;
          state_d    = (operator == OP_MUL) ? MUL : EXEC;
        end
      end
      EXEC: begin
        result_d   = exec_res;
        op_error_d = exec_illegal;
        state_d    = DONE;
      end
      MUL: begin
        // a_q is the shifting multiplicand, b_q the shifting multiplier.
        acc_d = acc_q + (b_q[0] ? a_q : '0);
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SHW'(WIDTH - 1)) begin
          result_d = acc_d;
          state_d  = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      op_q       <= '0;
      cnt_q      <= '0;
      op_error_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      op_error_q <= op_error_d;
    end
  end

  assign operation_done = (state_q == DONE);
  assign busy           = (state_q != IDLE);
  assign result         = result_q;
  assign op_error       = op_error_q;

endmodule

// File: tb/tb_alu_op_responder.sv
// tb/tb_alu_op_responder.sv - randomized self-checking bench for alu_op_responder.
module tb_alu_op_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] operand_a, operand_b;
  logic [7:0]  operator;
  logic        op_valid;
  logic        operation_done;
  logic [31:0] result;
  logic        busy;
  logic        op_error;

  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;

  alu_op_responder #(.WIDTH(32), .OP_WIDTH(8)) dut (
    .clock          (clock),
    .reset          (reset),
    .operand_a      (operand_a),
    .operand_b      (operand_b),
    .operator       (operator),
    .op_valid       (op_valid),
    .operation_done (operation_done),
    .result         (result),
    .busy           (busy),
    .op_error       (op_error)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (operation_done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic straight from the operator table.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic [7:0] op,
                       output logic [31:0] r, output logic e);
    e = 1'b0;
    case (op)
      8'd0: r = a + b;
      8'd1: r = a - b;
      8'd2: r = a & b;
      8'd3: r = a | b;
      8'd4: r = a ^ b;
      8'd5: r = a * b;
      8'd6: r = a << (b % 32);
      8'd7: r = a >> (b % 32);
      default: begin r = 32'd0; e = 1'b1; end
    endcase
  endtask

  // Issue one op from IDLE; optionally drive junk requests while busy.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [7:0] op,
                        input bit noise);
    int          lat;
    int          exp_lat;
    logic [31:0] exp_r;
    logic        exp_e;
    model(a, b, op, exp_r, exp_e);
    exp_lat   = (op == 8'd5) ? 32 : 1;
    operand_a = a;
    operand_b = b;
    operator  = op;
    op_valid  = 1'b1;
    @(negedge clock);
    check("busy_after_accept", busy, 1);
    op_valid = 1'b0;
    lat = 0;
    while (!operation_done && lat < 100) begin
      if (noise) begin
        op_valid  = 1'b1;
        operator  = 8'($urandom);
        operand_a = $urandom;
        operand_b = $urandom;
      end
      @(negedge clock);
      lat++;
    end
    op_valid = 1'b0;
    check("latency", lat, exp_lat);
    check("result", result, exp_r);
    check("op_error", op_error, exp_e);
    check("busy_in_done", busy, 1);
    @(negedge clock);
    check("done_single_pulse", operation_done, 0);
    check("busy_after_done", busy, 0);
    check("result_hold", result, exp_r);
  endtask

  initial begin
    int          d0;
    int          last;
    int          pulses;
    int          t;
    logic [7:0]  rop;

    reset     = 1'b0;
    operand_a = '0;
    operand_b = '0;
    operator  = '0;
    op_valid  = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_done", operation_done, 0);
    check("rst_result", result, 0);
    check("rst_busy", busy, 0);
    check("rst_err", op_error, 0);
    reset = 1'b1;
    @(negedge clock);

    run_op(32'hFFFF_FFFF, 32'd1, 8'd0, 0);
    run_op(32'd3, 32'd5, 8'd1, 0);
    run_op(32'd1, 32'h0000_0023, 8'd6, 0);

    d0 = done_cnt;
    run_op(32'h0001_0003, 32'h0000_0010, 8'd5, 1);
    check("mul_one_done", done_cnt - d0, 1);

    run_op(32'd7, 32'd9, 8'h80, 0);
    run_op(32'd6, 32'd3, 8'd2, 0);

    // Abort a multiply with reset partway through.
    operand_a = 32'd5;
    operand_b = 32'd7;
    operator  = 8'd5;
    op_valid  = 1'b1;
    @(negedge clock);
    op_valid = 1'b0;
    repeat (9) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("abort_done", operation_done, 0);
    check("abort_result", result, 0);
    check("abort_busy", busy, 0);
    check("abort_err", op_error, 0);
    d0 = done_cnt;
    repeat (40) @(negedge clock);
    check("abort_no_done", done_cnt - d0, 0);
    reset = 1'b1;
    @(negedge clock);
    run_op(32'd2, 32'd2, 8'd0, 0);

    // op_valid held high: one XOR every third cycle.
    operand_a = 32'hF0F0_F0F0;
    operand_b = 32'hFF00_FF00;
    operator  = 8'd4;
    op_valid  = 1'b1;
    last      = -1;
    pulses    = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (operation_done) begin
        check("b2b_result", result, 32'h0FF0_0FF0);
        if (last >= 0) check("b2b_gap", i - last, 3);
        last = i;
        pulses++;
      end
    end
    op_valid = 1'b0;
    check("b2b_pulses", pulses, 10);
    t = 0;
    while (busy && t < 100) begin
      @(negedge clock);
      t++;
    end
    check("b2b_idle", busy, 0);

    for (int n = 0; n < 150; n++) begin
      rop = 8'($urandom_range(0, 9));
      if (rop > 8'd7) rop = 8'(8 + $urandom_range(0, 247));
      run_op($urandom, $urandom, rop, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
